// File: rtl/nfc_cmd_queue_pkg.sv
// rtl/nfc_cmd_queue_pkg.sv - shared command layout, transfer limits and controller state encoding
package nfc_cmd_queue_pkg;

    localparam int CMD_W      = 33;
    localparam int RW_BIT     = 32;
    localparam int FADDR_HI   = 31;
    localparam int FADDR_LO   = 14;
    localparam int MADDR_HI   = 13;
    localparam int MADDR_LO   = 7;
    localparam int LEN_HI     = 6;
    localparam int LEN_LO     = 0;

    localparam int PAGE_BYTES = 512;
    localparam int MEM_WORDS  = 128;
    localparam int PAGE_OFS_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } ctl_state_t;

    // A command is legal when it neither crosses a flash page nor wraps the
    // memory window; a length field of zero means a full 128-word transfer.
    function automatic logic cmd_in_bounds(
        input logic [PAGE_OFS_W-1:0] page_ofs,
        input logic [6:0]            maddr,
        input logic [6:0]            len
    );
        logic [9:0] len_eff;
        logic [9:0] page_end;
        logic [9:0] mem_end;
        len_eff  = (len == 7'd0) ? 10'd128 : {3'd0, len};
        page_end = {1'b0, page_ofs} + len_eff;
        mem_end  = {3'd0, maddr} + len_eff;
        return (page_end <= 10'(PAGE_BYTES)) && (mem_end <= 10'(MEM_WORDS));
    endfunction

endpackage

// File: rtl/nfc_cmd_fifo.sv
// rtl/nfc_cmd_fifo.sv - command FIFO with wrap-bit pointers and show-ahead head
module nfc_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [4:0]       count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A write while full is only taken when the head leaves on the same edge.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign count   = 5'(wr_ptr - rd_ptr);

    // Pointer update; reset empties the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/nfc_cmd_queue.sv
// rtl/nfc_cmd_queue.sv - validated command queue feeding an NFC controller
module nfc_cmd_queue
    import nfc_cmd_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [CMD_W-1:0] push_cmd,
    output logic [CMD_W-1:0] cmd,
    output logic             nfc_rst,
    input  logic             done,
    output logic             busy,
    output logic [4:0]       q_count,
    output logic             err,
    output logic [15:0]      cmp_count
);

    ctl_state_t       state_q;
    ctl_state_t       state_d;
    logic [CMD_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             cmp_inc;
    logic             cmd_ok;
    logic             slot_free;
    logic             accept;
    logic [CMD_W-1:0] cmd_q;
    logic [15:0]      cmp_q;
    logic             err_q;

    assign cmd_ok = cmd_in_bounds(push_cmd[FADDR_LO+PAGE_OFS_W-1:FADDR_LO],
                                  push_cmd[MADDR_HI:MADDR_LO],
                                  push_cmd[LEN_HI:LEN_LO]);

    // push_ready reflects occupancy only; a full queue still takes a push on
    // the edge where the controller pops the head.
    assign push_ready = !fifo_full;
    assign slot_free  = !fifo_full || pop;
    assign accept     = push_valid && cmd_ok && slot_free;

    nfc_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_data (push_cmd),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (q_count)
    );

    // Controller state register; reset forces IDLE so nfc_rst rises at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and pop decisions; the cmd register loads only on a pop.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        cmp_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (done) begin
                    cmp_inc = 1'b1;
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Command register, completion counter and reject flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q <= '0;
            cmp_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (pop) begin
                cmd_q <= fifo_head;
            end
            if (cmp_inc) begin
                cmp_q <= cmp_q + 16'd1;
            end
            err_q <= push_valid && !cmd_ok && slot_free;
        end
    end

    assign cmd       = cmd_q;
    assign cmp_count = cmp_q;
    assign err       = err_q;
    assign nfc_rst   = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nfc_cmd_queue.sv
// tb/tb_nfc_cmd_queue.sv - directed scoreboard bench for nfc_cmd_queue
`timescale 1ns/1ps
module tb_nfc_cmd_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [32:0] push_cmd = '0;
    logic [32:0] cmd;
    logic        nfc_rst;
    logic        done = 1'b0;
    logic        busy;
    logic [4:0]  q_count;
    logic        err;
    logic [15:0] cmp_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [32:0] exp_q [$];
    logic [32:0] fill_cmds [DEPTH+1];
    logic [32:0] ca, cb, cc, cg, cx;
    logic [15:0] cmp_exp = '0;

    nfc_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_cmd   (push_cmd),
        .cmd        (cmd),
        .nfc_rst    (nfc_rst),
        .done       (done),
        .busy       (busy),
        .q_count    (q_count),
        .err        (err),
        .cmp_count  (cmp_count)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] mk(input logic rw, input logic [17:0] fa,
                                       input logic [6:0] ma, input logic [6:0] ln);
        return {rw, fa, ma, ln};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_load(input string tag);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=<scoreboard empty>", tag, cmd);
        end else begin
            check(tag, 64'(cmd), 64'(exp_q.pop_front()));
        end
    endtask

    task automatic push_one(input logic [32:0] c, input bit exp_ok);
        push_valid = 1'b1;
        push_cmd   = c;
        if (exp_ok) exp_q.push_back(c);
        step();
        push_valid = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_nfc_rst", 64'(nfc_rst), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_q_count", 64'(q_count), 64'd0);
        check("rst_cmd", 64'(cmd), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_cmp", 64'(cmp_count), 64'd0);
        check("rst_ready", 64'(push_ready), 64'd1);
        rst = 1'b1;
        step();
        check("rel_nfc_rst", 64'(nfc_rst), 64'd1);

        // Single read command through launch and one completion
        cx = mk(1'b1, 18'h00100, 7'd0, 7'd16);
        push_one(cx, 1'b1);
        check("t1_q_after_push", 64'(q_count), 64'd1);
        check("t1_still_idle", 64'(nfc_rst), 64'd1);
        step();
        check("t1_launch_nfc_rst", 64'(nfc_rst), 64'd0);
        check("t1_launch_busy", 64'(busy), 64'd1);
        expect_load("t1_cmd_load");
        check("t1_q_drained", 64'(q_count), 64'd0);
        repeat (3) step();
        check("t1_cmd_hold", 64'(cmd), 64'(cx));
        pulse_done();
        check("t1_run_nfc_rst", 64'(nfc_rst), 64'd0);
        check("t1_cmd_hold2", 64'(cmd), 64'(cx));
        check("t1_cmp_mid", 64'(cmp_count), 64'd0);
        step();
        pulse_done();
        cmp_exp++;
        check("t1_end_nfc_rst", 64'(nfc_rst), 64'd1);
        check("t1_end_cmp", 64'(cmp_count), 64'(cmp_exp));
        check("t1_end_cmd", 64'(cmd), 64'(cx));

        // Three back-to-back commands
        ca = mk(1'b0, 18'h00200, 7'd10, 7'd20);
        cb = mk(1'b1, 18'h01010, 7'd40, 7'd64);
        cc = mk(1'b0, 18'h201C0, 7'd0, 7'd64);
        push_one(ca, 1'b1);
        check("t2_q1", 64'(q_count), 64'd1);
        push_one(cb, 1'b1);
        expect_load("t2_load_a");
        check("t2_q_pushpop", 64'(q_count), 64'd1);
        check("t2_nfc_rst0", 64'(nfc_rst), 64'd0);
        push_one(cc, 1'b1);
        check("t2_q2", 64'(q_count), 64'd2);
        pulse_done();
        check("t2_cmd_a_held", 64'(cmd), 64'(ca));
        step();
        pulse_done();
        cmp_exp++;
        expect_load("t2_load_b");
        check("t2_nfc_rst_b", 64'(nfc_rst), 64'd0);
        check("t2_q_b", 64'(q_count), 64'd1);
        pulse_done();
        cmp_exp++;
        expect_load("t2_load_c");
        check("t2_nfc_rst_c", 64'(nfc_rst), 64'd0);
        pulse_done();
        cmp_exp++;
        check("t2_end_nfc_rst", 64'(nfc_rst), 64'd1);
        check("t2_end_cmp", 64'(cmp_count), 64'(cmp_exp));

        // Rejected commands and an exact-fit legal one
        push_one(mk(1'b0, 18'd500, 7'd0, 7'd16), 1'b0);
        check("t3_page_err", 64'(err), 64'd1);
        check("t3_page_q", 64'(q_count), 64'd0);
        step();
        check("t3_page_err_once", 64'(err), 64'd0);
        check("t3_page_nfc_rst", 64'(nfc_rst), 64'd1);
        push_one(mk(1'b1, 18'd0, 7'd120, 7'd16), 1'b0);
        check("t3_mem_err", 64'(err), 64'd1);
        push_one(mk(1'b0, 18'd0, 7'd1, 7'd0), 1'b0);
        check("t3_len0_err", 64'(err), 64'd1);
        check("t3_len0_q", 64'(q_count), 64'd0);
        push_one(mk(1'b1, 18'd384, 7'd0, 7'd0), 1'b1);
        check("t3_fit_no_err", 64'(err), 64'd0);
        check("t3_fit_q", 64'(q_count), 64'd1);
        step();
        expect_load("t3_fit_load");
        pulse_done();
        pulse_done();
        cmp_exp++;
        check("t3_fit_cmp", 64'(cmp_count), 64'(cmp_exp));

        // Fill to full with done low, drop one, then push+pop while full
        for (int i = 0; i <= DEPTH; i++) begin
            fill_cmds[i] = mk(i[0], 18'(i * 16), 7'(i * 8), 7'd8);
        end
        push_one(mk(1'b0, 18'h3F000, 7'd0, 7'd1), 1'b1);
        step();
        expect_load("t4_first_load");
        pulse_done();
        for (int i = 0; i < DEPTH; i++) begin
            push_one(fill_cmds[i], 1'b1);
        end
        check("t4_full_count", 64'(q_count), 64'(DEPTH));
        check("t4_full_ready", 64'(push_ready), 64'd0);
        push_one(fill_cmds[DEPTH], 1'b0);
        check("t4_drop_count", 64'(q_count), 64'(DEPTH));
        check("t4_drop_err", 64'(err), 64'd0);
        cg = mk(1'b1, 18'h30000, 7'd100, 7'd28);
        push_valid = 1'b1;
        push_cmd   = cg;
        done       = 1'b1;
        exp_q.push_back(cg);
        step();
        push_valid = 1'b0;
        done       = 1'b0;
        cmp_exp++;
        expect_load("t4_simul_load");
        check("t4_simul_count", 64'(q_count), 64'(DEPTH));
        check("t4_simul_cmp", 64'(cmp_count), 64'(cmp_exp));
        for (int i = 0; i < DEPTH - 2; i++) begin
            pulse_done();
            cmp_exp++;
            expect_load("t4_drain_load");
        end
        check("t4_two_left", 64'(q_count), 64'd2);
        check("t4_running", 64'(busy), 64'd1);

        // Asynchronous reset in RUN with two queued
        rst = 1'b0;
        #1;
        check("t5_async_nfc_rst", 64'(nfc_rst), 64'd1);
        check("t5_async_busy", 64'(busy), 64'd0);
        check("t5_async_q", 64'(q_count), 64'd0);
        check("t5_async_cmd", 64'(cmd), 64'd0);
        check("t5_async_cmp", 64'(cmp_count), 64'd0);
        exp_q.delete();
        cmp_exp = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        check("t5_rel_ready", 64'(push_ready), 64'd1);
        push_one(cb, 1'b1);
        check("t5_post_q", 64'(q_count), 64'd1);
        step();
        expect_load("t5_post_load");
        check("t5_post_nfc_rst", 64'(nfc_rst), 64'd0);
        pulse_done();
        pulse_done();
        cmp_exp++;
        check("t5_post_idle", 64'(nfc_rst), 64'd1);
        check("t5_post_cmp", 64'(cmp_count), 64'(cmp_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nfc_cmd_queue.md
NFC_CMD_QUEUE -- requirements
Module: nfc_cmd_queue

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low, ports named as below.
REQ-002 Parameter DEPTH, default 8, power of two, 2..16: number of command FIFO entries.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 push_valid  input  1  host offers push_cmd this cycle.
REQ-006 push_ready  output  1  FIFO can accept (not full).
REQ-007 push_cmd  input  33  host command: [32] RW (1 = flash-to-memory), [31:14] flash address, [13:7] memory address, [6:0] length (0 encodes 128).
REQ-008 cmd  output  33  command presented to the NFC controller.
REQ-009 nfc_rst  output  1  active-high hold-in-reset to the NFC controller.
REQ-010 done  input  1  NFC completion/idle strobe, high for exactly one cycle.
REQ-011 busy  output  1  an NFC command is in flight.
REQ-012 q_count  output  5  FIFO occupancy, 0..DEPTH.
REQ-013 err  output  1  one-cycle pulse: the pushed command was rejected.
REQ-014 cmp_count  output  16  number of NFC commands completed, wraps at 65535 -> 0.

Function
REQ-015 A push SHALL occur on any cycle with push_valid=1 and push_ready=1.
REQ-016 A push SHALL be rejected (not stored; err=1 on the next cycle) when addr[8:0] + len > 512 (the transfer crosses a 512-byte page) or when maddr + len > 128 (the memory range wraps); len 0 counts as 128.
REQ-017 push_ready SHALL equal (q_count != DEPTH); pushes while full are ignored.
REQ-018 Controller states SHALL be: IDLE (nfc_rst=1, busy=0), LAUNCH (nfc_rst=0, busy=1), RUN (nfc_rst=0, busy=1).
REQ-019 IDLE -> LAUNCH when the FIFO is non-empty: the head is popped into the cmd register and nfc_rst is deasserted on the same edge.
REQ-020 In LAUNCH, the first done (NFC start-up idle) SHALL move the FSM to RUN; cmd stays unchanged.
REQ-021 In RUN, a done at the end of a cycle SHALL increment cmp_count. If the FIFO is non-empty, the next head loads into cmd on that same edge and the FSM stays in RUN. Otherwise nfc_rst is asserted on that edge and the FSM goes to IDLE.
REQ-022 cmd SHALL change only on the edges defined in REQ-019 and REQ-021; it is held stable otherwise, because the NFC reads it combinationally for the whole operation.
REQ-023 Push and pop in the same cycle SHALL be allowed, leaving q_count unchanged. When full, a simultaneous push and pop is accepted.
REQ-024 A push into an empty FIFO while in IDLE SHALL launch on the following edge: latency is 1 cycle from push to nfc_rst=0.
REQ-025 done seen while in IDLE SHALL be ignored.
REQ-026 FIFO read and write pointers SHALL use log2(DEPTH)+1 bits, with the wrap bit distinguishing full from empty.

Reset
REQ-027 While rst=0 the block SHALL hold: FSM=IDLE, nfc_rst=1, busy=0, cmd=0, pointers=0, q_count=0, err=0, cmp_count=0.
REQ-028 Reset asserted mid-operation SHALL discard queued and in-flight commands, with nfc_rst reasserted immediately (asynchronously).
REQ-029 Release of rst SHALL take effect on the first clk edge after rst returns to 1.

Structure
REQ-030 A shared package SHALL hold: the command field positions (RW bit 32, FADDR 31:14, MADDR 13:7, LEN 6:0), the PAGE_BYTES=512 and MEM_WORDS=128 constants, and the FSM state encoding.
REQ-031 The FIFO SHALL be a separate sub-module named nfc_cmd_fifo (parameter DEPTH, width 33); the validity check and FSM stay in the top level.

Verification
REQ-032 Reset, then push one read cmd {1,18'h00100,7'd0,7'd16} -> nfc_rst falls 1 cycle later; cmd holds that value through two done pulses; then nfc_rst=1, cmp_count=1.
REQ-033 Push 3 commands back-to-back -> each cmd change coincides with a done edge; nfc_rst stays 0 throughout; cmp_count=3 at the end.
REQ-034 Push addr[8:0]=9'd500, len=16 -> err pulses once, q_count stays 0, nfc_rst stays 1.
REQ-035 Push DEPTH+1 commands with done held low -> push_ready=0 at q_count=8 and the 9th command is dropped. A simultaneous push and done-pop at full is then accepted, leaving q_count=8.
REQ-036 Drive rst=0 while in RUN with 2 queued -> nfc_rst=1 immediately, q_count=0, cmd=0; a post-reset push launches normally.
